// File: rtl/cd_frame_ring.sv
// Ring of FRAME_NUM byte-addressed frame slots. The writer always owns one slot,
// and committed slots are read back oldest-first together with their flag word.
module cd_frame_ring #(
  parameter int FRAME_NUM = 4,
  parameter int ADDR_W    = 8,
  parameter int FLAG_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  wr_byte,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic                        wr_en,
  input  logic [FLAG_W-1:0]           wr_flags,
  input  logic                        switch,
  output logic                        switch_fail,
  input  logic [ADDR_W-1:0]           rd_addr,
  input  logic                        rd_en,
  output logic [7:0]                  rd_byte,
  output logic [FLAG_W-1:0]           rd_flags,
  input  logic                        rd_done,
  input  logic                        rd_done_all,
  output logic                        unread,
  output logic [$clog2(FRAME_NUM):0]  frame_cnt,
  output logic [7:0]                  lost_cnt
);

  localparam int SEL_W = $clog2(FRAME_NUM);
  localparam int CNT_W = SEL_W + 1;
  localparam int DEPTH = FRAME_NUM << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_NUM - 1);

  logic [7:0]        mem [DEPTH];
  logic [FLAG_W-1:0] flags [FRAME_NUM];

  logic [SEL_W-1:0] wr_sel, wr_sel_nxt;
  logic [SEL_W-1:0] rd_sel, rd_sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             full;
  logic             commit;
  logic             pop;
  logic             fail;

  assign full      = (cnt == CNT_FULL);
  assign unread    = (cnt != '0);
  assign frame_cnt = cnt;
  assign rd_flags  = flags[rd_sel];

  // A release in the same cycle frees a slot before the commit is judged,
  // and a flush frees everything, so only a bare switch on a full ring fails.
  always_comb begin
    commit     = 1'b0;
    pop        = 1'b0;
    fail       = 1'b0;
    wr_sel_nxt = wr_sel;
    rd_sel_nxt = rd_sel;
    cnt_nxt    = cnt;
    if (rd_done_all) begin
      rd_sel_nxt = wr_sel;
      commit     = switch;
      cnt_nxt    = switch ? CNT_W'(1) : '0;
    end else begin
      pop    = rd_done && (cnt != '0);
      commit = switch && (!full || pop);
      fail   = switch && !commit;
      if (pop) begin
        rd_sel_nxt = rd_sel + 1'b1;
      end
      if (commit && !pop) begin
        cnt_nxt = cnt + CNT_W'(1);
      end else if (pop && !commit) begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
    if (commit) begin
      wr_sel_nxt = wr_sel + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_sel      <= '0;
      rd_sel      <= '0;
      cnt         <= '0;
      switch_fail <= 1'b0;
      lost_cnt    <= '0;
    end else begin
      wr_sel      <= wr_sel_nxt;
      rd_sel      <= rd_sel_nxt;
      cnt         <= cnt_nxt;
      switch_fail <= fail;
      if (fail && (lost_cnt != 8'hFF)) begin
        lost_cnt <= lost_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FRAME_NUM; i++) begin
        flags[i] <= '0;
      end
    end else if (commit) begin
      flags[wr_sel] <= wr_flags;
    end
  end

  // Frame storage has no reset; a read of the address being written sees the old byte.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_sel, wr_addr}] <= wr_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_byte <= '0;
    end else if (rd_en) begin
      rd_byte <= mem[{rd_sel, rd_addr}];
    end
  end

endmodule

// File: tb/tb_cd_frame_ring.sv
// Randomised bench for cd_frame_ring: a queue-of-frames reference model predicts
// every output each cycle, plus directed scenarios for the corner cases.
module tb_cd_frame_ring;

  localparam int FRAME_NUM = 4;
  localparam int ADDR_W    = 8;
  localparam int FLAG_W    = 8;
  localparam int SLOT      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        wr_byte;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic [FLAG_W-1:0] wr_flags;
  logic              switch;
  logic              switch_fail;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [7:0]        rd_byte;
  logic [FLAG_W-1:0] rd_flags;
  logic              rd_done;
  logic              rd_done_all;
  logic              unread;
  logic [2:0]        frame_cnt;
  logic [7:0]        lost_cnt;

  cd_frame_ring #(
    .FRAME_NUM(FRAME_NUM),
    .ADDR_W   (ADDR_W),
    .FLAG_W   (FLAG_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_byte    (wr_byte),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .wr_flags   (wr_flags),
    .switch     (switch),
    .switch_fail(switch_fail),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_byte    (rd_byte),
    .rd_flags   (rd_flags),
    .rd_done    (rd_done),
    .rd_done_all(rd_done_all),
    .unread     (unread),
    .frame_cnt  (frame_cnt),
    .lost_cnt   (lost_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SLOT-1:0][7:0] data;
    logic [SLOT-1:0]      known;
    logic [7:0]           flags;
  } frame_t;

  frame_t     q[$];
  frame_t     wbuf;
  logic [7:0] expRd;
  bit         expKnown;
  logic [7:0] expLost;
  bit         expFail;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clearInputs();
    wr_byte     = '0;
    wr_addr     = '0;
    wr_en       = 1'b0;
    wr_flags    = '0;
    switch      = 1'b0;
    rd_addr     = '0;
    rd_en       = 1'b0;
    rd_done     = 1'b0;
    rd_done_all = 1'b0;
  endtask

  task automatic modelReset();
    q.delete();
    wbuf.known = '0;
    expRd      = '0;
    expKnown   = 1'b1;
    expLost    = '0;
    expFail    = 1'b0;
  endtask

  task automatic commitWriter();
    wbuf.flags = wr_flags;
    q.push_back(wbuf);
    wbuf.known = '0;
  endtask

  task automatic modelStep();
    if (rd_en) begin
      if (q.size() > 0) begin
        expRd    = q[0].data[rd_addr];
        expKnown = q[0].known[rd_addr];
      end else begin
        expRd    = wbuf.data[rd_addr];
        expKnown = wbuf.known[rd_addr];
      end
    end
    if (wr_en) begin
      wbuf.data[wr_addr]  = wr_byte;
      wbuf.known[wr_addr] = 1'b1;
    end
    expFail = 1'b0;
    if (rd_done_all) begin
      q.delete();
      if (switch) commitWriter();
    end else begin
      if (rd_done && q.size() > 0) void'(q.pop_front());
      if (switch) begin
        if (q.size() < FRAME_NUM - 1) begin
          commitWriter();
        end else begin
          expFail = 1'b1;
          if (expLost != 8'hFF) expLost = expLost + 8'd1;
        end
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("switch_fail", 32'(switch_fail), 32'(expFail));
    checkOutput("unread", 32'(unread), 32'(q.size() != 0));
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(q.size()));
    checkOutput("lost_cnt", 32'(lost_cnt), 32'(expLost));
    if (expKnown) checkOutput("rd_byte", 32'(rd_byte), 32'(expRd));
    if (q.size() > 0) checkOutput("rd_flags", 32'(rd_flags), 32'(q[0].flags));
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
    clearInputs();
  endtask

  task automatic writeByte(input logic [ADDR_W-1:0] a, input logic [7:0] b);
    wr_en = 1'b1; wr_addr = a; wr_byte = b;
    applyStimulus();
  endtask

  task automatic commitFrame(input logic [7:0] f);
    writeByte(8'($urandom_range(0, 7)), 8'($urandom));
    switch = 1'b1; wr_flags = f;
    applyStimulus();
  endtask

  task automatic randomCycles(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en       = ($urandom_range(0, 1) == 1);
      wr_addr     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      wr_byte     = 8'($urandom);
      wr_flags    = 8'($urandom);
      switch      = ($urandom_range(0, 3) == 0);
      rd_en       = ($urandom_range(0, 1) == 1);
      rd_addr     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      rd_done     = ($urandom_range(0, 4) == 0);
      rd_done_all = ($urandom_range(0, 31) == 0);
      applyStimulus();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b1;
    logic [7:0] f [3];
    clearInputs();
    modelReset();
    reset = 1'b1;
    #23 reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_rd_flags", 32'(rd_flags), 32'h0);
    checkAll();

    // Three bytes then a commit with flags 0x81; read back address 1.
    writeByte(8'd0, 8'($urandom));
    b1 = 8'($urandom);
    writeByte(8'd1, b1);
    writeByte(8'd2, 8'($urandom));
    switch = 1'b1; wr_flags = 8'h81;
    applyStimulus();
    checkOutput("first_unread", 32'(unread), 32'h1);
    checkOutput("first_flags", 32'(rd_flags), 32'h81);
    rd_en = 1'b1; rd_addr = 8'd1;
    applyStimulus();
    checkOutput("first_rd_byte", 32'(rd_byte), 32'(b1));
    rd_done = 1'b1;
    applyStimulus();

    // Fill the ring, then overflow it until the lost counter saturates.
    for (int i = 0; i < 3; i++) begin
      f[i] = 8'($urandom);
      commitFrame(f[i]);
    end
    switch = 1'b1;
    applyStimulus();
    checkOutput("full_fail_pulse", 32'(switch_fail), 32'h1);
    checkOutput("full_lost_one", 32'(lost_cnt), 32'h1);
    checkOutput("full_cnt", 32'(frame_cnt), 32'h3);
    for (int i = 0; i < 300; i++) begin
      switch = 1'b1;
      applyStimulus();
    end
    checkOutput("lost_saturated", 32'(lost_cnt), 32'hFF);
    applyStimulus();
    checkOutput("fail_drops", 32'(switch_fail), 32'h0);

    // Commit and release together while full.
    switch = 1'b1; rd_done = 1'b1; wr_flags = 8'h3C;
    applyStimulus();
    checkOutput("full_swap_fail", 32'(switch_fail), 32'h0);
    checkOutput("full_swap_cnt", 32'(frame_cnt), 32'h3);
    checkOutput("full_swap_head", 32'(rd_flags), 32'(f[1]));

    // Flush together with a commit keeps only the new frame.
    rd_done_all = 1'b1;
    applyStimulus();
    commitFrame(8'h11);
    commitFrame(8'h22);
    writeByte(8'd5, 8'hA7);
    rd_done_all = 1'b1; switch = 1'b1; wr_flags = 8'h5A;
    applyStimulus();
    checkOutput("flush_commit_cnt", 32'(frame_cnt), 32'h1);
    checkOutput("flush_commit_flags", 32'(rd_flags), 32'h5A);
    rd_en = 1'b1; rd_addr = 8'd5;
    applyStimulus();
    checkOutput("flush_commit_data", 32'(rd_byte), 32'hA7);

    // Release on an empty ring is ignored; then wrap the pointers.
    rd_done_all = 1'b1;
    applyStimulus();
    rd_done = 1'b1;
    applyStimulus();
    checkOutput("empty_release_cnt", 32'(frame_cnt), 32'h0);
    for (int i = 0; i < 10; i++) begin
      writeByte(8'(i), 8'($urandom));
      commitFrame(8'(i + 8'h40));
      rd_en = 1'b1; rd_addr = 8'(i);
      applyStimulus();
      checkOutput("wrap_flags", 32'(rd_flags), 32'(i + 8'h40));
      rd_done = 1'b1;
      applyStimulus();
    end

    randomCycles(1500);

    // Asynchronous reset between edges with two frames pending.
    rd_done_all = 1'b1;
    applyStimulus();
    commitFrame(8'h77);
    writeByte(8'd3, 8'hC3);
    commitFrame(8'h78);
    rd_en = 1'b1; rd_addr = 8'd3;
    applyStimulus();
    switch = 1'b1;
    applyStimulus();
    #2 reset = 1'b1;
    #1;
    checkOutput("async_unread", 32'(unread), 32'h0);
    checkOutput("async_frame_cnt", 32'(frame_cnt), 32'h0);
    checkOutput("async_lost_cnt", 32'(lost_cnt), 32'h0);
    checkOutput("async_rd_byte", 32'(rd_byte), 32'h0);
    checkOutput("async_rd_flags", 32'(rd_flags), 32'h0);
    #2 reset = 1'b0;
    modelReset();
    @(posedge clk); #1;
    checkAll();

    randomCycles(500);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
